ascon_ctrl: RTL

ASCON_CTRL -- requirements
Module: ascon_ctrl

---
 rtl/ascon_pack.sv | 38 +++
 rtl/ascon_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon definitions.
//   ROUND_NO     : rounds of the longest permutation (p^a)
//   ROUND_WIDTH  : width of the round index driven to the datapath
//   ascon_ctrl_state_e : control FSM states
//   ascon_ctrl_out_t   : bundle of the controller's datapath/status outputs
package ascon_pack;

  localparam int ROUND_NO    = 12;
  localparam int ROUND_WIDTH = $clog2(ROUND_NO);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD_WAIT,
    AD_RND,
    PT_WAIT,
    PT_RND,
    FINAL,
    DONE
  } ascon_ctrl_state_e;

  typedef struct packed {
    logic                   en_state;
    logic                   sel_ad;
    logic                   sel_state_init;
    logic                   sel_xor_init;
    logic                   sel_xor_ext;
    logic                   sel_xor_dom_sep;
    logic                   sel_xor_fin;
    logic                   sel_xor_tag;
    logic                   ct_valid;
    logic                   tag_valid;
    logic                   busy;
    logic                   done;
    logic [ROUND_WIDTH-1:0] rnd;
  } ascon_ctrl_out_t;

endpackage

// File: rtl/ascon_ctrl.sv
// Ascon-128 encryption controller. Sequences p^a / p^b rounds and drives the
// select lines of the permutation datapath.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i, ad_empty_i        start a new encryption (sampled in IDLE/DONE)
//   ad_valid_i/ad_last_i/ad_ready_o   associated-data block stream
//   pt_valid_i/pt_last_i/pt_ready_o   plaintext block stream (pre-padded)
//   en_state_o, sel_*_o        datapath state enable and mux/XOR selects
//   ct_valid_o, tag_valid_o    output qualifiers
//   rnd_o                      round index
//   busy_o, done_o             status
//   state_o                    current FSM state (debug visibility)
//
// Handshake: a block transfers in the cycle where valid and ready are both
// high. ready depends only on state (AD_WAIT / PT_WAIT), never on valid, and
// valid on a stream is ignored in every other state. The transfer cycle is
// itself round 0 of the p^b (or final p^a) permutation, so its selects are
// decoded from the valid input in that same cycle; the start cycle is handled
// the same way as round 0 of the initial p^a. All other outputs come from
// flops whose next value is decoded from the next state and round.
//
// Requires PB_ROUNDS >= 2 and PA_ROUNDS >= PB_ROUNDS.
module ascon_ctrl
  import ascon_pack::*;
#(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   ad_empty_i,
  input  logic                   ad_valid_i,
  input  logic                   ad_last_i,
  output logic                   ad_ready_o,
  input  logic                   pt_valid_i,
  input  logic                   pt_last_i,
  output logic                   pt_ready_o,
  output logic                   en_state_o,
  output logic                   sel_ad_o,
  output logic                   sel_state_init_o,
  output logic                   sel_xor_init_o,
  output logic                   sel_xor_ext_o,
  output logic                   sel_xor_dom_sep_o,
  output logic                   sel_xor_fin_o,
  output logic                   sel_xor_tag_o,
  output logic                   ct_valid_o,
  output logic                   tag_valid_o,
  output logic [ROUND_WIDTH-1:0] rnd_o,
  output logic                   busy_o,
  output logic                   done_o,
  output ascon_ctrl_state_e      state_o
);

  // p^a runs rounds 0..PA-1, p^b runs the tail PA-PB..PA-1 of the same index.
  localparam logic [ROUND_WIDTH-1:0] RND_LAST = ROUND_WIDTH'(PA_ROUNDS - 1);
  localparam logic [ROUND_WIDTH-1:0] RND_B0   = ROUND_WIDTH'(PA_ROUNDS - PB_ROUNDS);
  localparam logic [ROUND_WIDTH-1:0] RND_ONE  = ROUND_WIDTH'(1);

  ascon_ctrl_state_e      state_q, state_d;
  logic [ROUND_WIDTH-1:0] rnd_q, rnd_d;
  logic                   ad_empty_q, ad_empty_d;
  logic                   ad_last_q, ad_last_d;
  ascon_ctrl_out_t        out_q, out_d, ovl, ovl_gated, out_all;

  // Outputs of a cycle spent inside a permutation or status state; used to
  // precompute the registered outputs from the next state.
  function automatic ascon_ctrl_out_t perm_decode(input ascon_ctrl_state_e st,
                                                  input logic [ROUND_WIDTH-1:0] rnd,
                                                  input logic ad_empty,
                                                  input logic ad_last);
    ascon_ctrl_out_t o;
    o      = '0;
    o.busy = (st != IDLE) && (st != DONE);
    case (st)
      INIT: begin
        o.en_state = 1'b1;
        o.rnd      = rnd;
        if (rnd == RND_LAST) begin
          o.sel_xor_init    = 1'b1;
          o.sel_xor_dom_sep = ad_empty;
        end
      end
      AD_RND: begin
        o.en_state = 1'b1;
        o.rnd      = rnd;
        if (rnd == RND_LAST) o.sel_xor_dom_sep = ad_last;
      end
      PT_RND: begin
        o.en_state = 1'b1;
        o.rnd      = rnd;
      end
      FINAL: begin
        o.en_state = 1'b1;
        o.rnd      = rnd;
        if (rnd == RND_LAST) o.sel_xor_tag = 1'b1;
      end
      DONE: begin
        o.done      = 1'b1;
        o.tag_valid = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    ad_empty_d = ad_empty_q;
    ad_last_d  = ad_last_q;
    ad_ready_o = 1'b0;
    pt_ready_o = 1'b0;
    ovl        = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          ovl.en_state       = 1'b1;
          ovl.sel_state_init = 1'b1;
          ad_empty_d         = ad_empty_i;
          state_d            = INIT;
          rnd_d              = RND_ONE;
        end
      end
      INIT: begin
        if (rnd_q == RND_LAST) begin
          state_d = ad_empty_q ? PT_WAIT : AD_WAIT;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + RND_ONE;
        end
      end
      AD_WAIT: begin
        ad_ready_o = 1'b1;
        if (ad_valid_i) begin
          ovl.en_state    = 1'b1;
          ovl.sel_xor_ext = 1'b1;
          ovl.sel_ad      = 1'b1;
          ovl.rnd         = RND_B0;
          ad_last_d       = ad_last_i;
          state_d         = AD_RND;
          rnd_d           = RND_B0 + RND_ONE;
        end
      end
      AD_RND: begin
        if (rnd_q == RND_LAST) begin
          state_d = ad_last_q ? PT_WAIT : AD_WAIT;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + RND_ONE;
        end
      end
      PT_WAIT: begin
        pt_ready_o = 1'b1;
        if (pt_valid_i) begin
          ovl.en_state    = 1'b1;
          ovl.sel_xor_ext = 1'b1;
          ovl.ct_valid    = 1'b1;
          if (pt_last_i) begin
            // Last block: key XOR before the final p^a, which restarts at 0.
            ovl.sel_xor_fin = 1'b1;
            state_d         = FINAL;
            rnd_d           = RND_ONE;
          end else begin
            ovl.rnd = RND_B0;
            state_d = PT_RND;
            rnd_d   = RND_B0 + RND_ONE;
          end
        end
      end
      PT_RND: begin
        if (rnd_q == RND_LAST) begin
          state_d = PT_WAIT;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + RND_ONE;
        end
      end
      FINAL: begin
        if (rnd_q == RND_LAST) begin
          state_d = DONE;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + RND_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_d = perm_decode(state_d, rnd_d, ad_empty_d, ad_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      ad_empty_q <= 1'b0;
      ad_last_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      ad_empty_q <= ad_empty_d;
      ad_last_q  <= ad_last_d;
      out_q      <= out_d;
    end
  end

  // The start/accept decode is combinational from inputs; mask it while in
  // reset so every output is 0 regardless of what the inputs are doing.
  assign ovl_gated = rst_n ? ovl : '0;
  assign out_all   = out_q | ovl_gated;

  assign en_state_o        = out_all.en_state;
  assign sel_ad_o          = out_all.sel_ad;
  assign sel_state_init_o  = out_all.sel_state_init;
  assign sel_xor_init_o    = out_all.sel_xor_init;
  assign sel_xor_ext_o     = out_all.sel_xor_ext;
  assign sel_xor_dom_sep_o = out_all.sel_xor_dom_sep;
  assign sel_xor_fin_o     = out_all.sel_xor_fin;
  assign sel_xor_tag_o     = out_all.sel_xor_tag;
  assign ct_valid_o        = out_all.ct_valid;
  assign tag_valid_o       = out_all.tag_valid;
  assign rnd_o             = out_all.rnd;
  assign busy_o            = out_all.busy;
  assign done_o            = out_all.done;
  assign state_o           = state_q;

endmodule
